// File: rtl/adder_tree_pipe.sv
// Pipelined N-input signed adder tree with saturating output and an optional
// multi-beat accumulate mode for dot-product partial sums.
module adder_tree_pipe #(
  parameter int DWIDTH    = 32,
  parameter int FRAC      = 24,
  parameter int N_IN      = 4,
  parameter int ACC_GUARD = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [N_IN*DWIDTH-1:0] in_data,
  input  logic                   acc_mode,
  input  logic                   in_last,
  output logic                   out_valid,
  output logic [DWIDTH-1:0]      out_data,
  output logic                   out_ovf
);

  localparam int S  = $clog2(N_IN);
  localparam int TW = DWIDTH + S;
  localparam int AW = TW + ACC_GUARD;
  localparam bit PARAMS_OK = (N_IN >= 2) && (N_IN <= 16) && (FRAC < DWIDTH);

  localparam logic signed [AW:0] DMAX = {{(AW+2-DWIDTH){1'b0}}, {(DWIDTH-1){1'b1}}};
  localparam logic signed [AW:0] DMIN = {{(AW+2-DWIDTH){1'b1}}, {(DWIDTH-1){1'b0}}};
  localparam logic signed [AW:0] AMAX = {2'b00, {(AW-1){1'b1}}};
  localparam logic signed [AW:0] AMIN = {2'b11, {(AW-1){1'b0}}};

  if (!PARAMS_OK) begin : g_illegal_params
  end

  typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

  function automatic int n_at(input int k);
    int n;
    n = N_IN;
    for (int j = 0; j < k; j++) n = (n + 1) / 2;
    return n;
  endfunction

  function automatic logic signed [DWIDTH-1:0] sat_dw(input logic signed [AW:0] x);
    if (x > DMAX) return DMAX[DWIDTH-1:0];
    if (x < DMIN) return DMIN[DWIDTH-1:0];
    return x[DWIDTH-1:0];
  endfunction

  function automatic logic ovf_dw(input logic signed [AW:0] x);
    return (x > DMAX) || (x < DMIN);
  endfunction

  function automatic logic signed [AW-1:0] sat_aw(input logic signed [AW:0] x);
    if (x > AMAX) return AMAX[AW-1:0];
    if (x < AMIN) return AMIN[AW-1:0];
    return x[AW-1:0];
  endfunction

  function automatic logic ovf_aw(input logic signed [AW:0] x);
    return (x > AMAX) || (x < AMIN);
  endfunction

  // Every level is kept at the final tree width; bits above DWIDTH+k are sign copies.
  logic signed [TW-1:0] op_p0  [N_IN];
  logic signed [TW-1:0] tree_d [S][N_IN];
  logic signed [TW-1:0] tree_q [S][N_IN];
  logic [S-1:0] vld_d, vld_q, mode_d, mode_q, last_d, last_q;

  always_comb begin
    for (int i = 0; i < N_IN; i++) op_p0[i] = TW'($signed(in_data[i*DWIDTH +: DWIDTH]));
  end

  always_comb begin
    for (int j = 0; j < S; j++)
      for (int i = 0; i < N_IN; i++) tree_d[j][i] = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (i < n_at(1)) begin
        if (2*i+1 < N_IN) tree_d[0][i] = op_p0[2*i] + op_p0[2*i+1];
        else              tree_d[0][i] = op_p0[2*i];
      end
    end
    for (int j = 1; j < S; j++) begin
      for (int i = 0; i < N_IN; i++) begin
        if (i < n_at(j+1)) begin
          if (2*i+1 < n_at(j)) tree_d[j][i] = tree_q[j-1][2*i] + tree_q[j-1][2*i+1];
          else                 tree_d[j][i] = tree_q[j-1][2*i];
        end
      end
    end
  end

  always_comb begin
    vld_d[0]  = in_valid;
    mode_d[0] = acc_mode;
    last_d[0] = in_last;
    for (int j = 1; j < S; j++) begin
      vld_d[j]  = vld_q[j-1];
      mode_d[j] = mode_q[j-1];
      last_d[j] = last_q[j-1];
    end
  end

  // ---- tree levels 1..S ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < S; j++)
        for (int i = 0; i < N_IN; i++) tree_q[j][i] <= '0;
      vld_q  <= '0;
      mode_q <= '0;
      last_q <= '0;
    end else begin
      tree_q <= tree_d;
      vld_q  <= vld_d;
      mode_q <= mode_d;
      last_q <= last_d;
    end
  end

  // ---- output stage: saturation, accumulate FSM ----
  state_t                  state_d, state_q;
  logic signed [AW-1:0]    accum_d, accum_q;
  logic                    sticky_d, sticky_q;
  logic                    out_valid_d, out_valid_q, out_ovf_d, out_ovf_q;
  logic [DWIDTH-1:0]       out_data_d, out_data_q;
  logic                    beat_vld, beat_acc, beat_last, acc_clamp;
  logic signed [AW:0]      sum_x, acc_x, acc_new_x;
  logic signed [AW-1:0]    acc_new;

  always_comb begin
    beat_vld  = vld_q[S-1];
    beat_acc  = mode_q[S-1];
    beat_last = last_q[S-1];
    sum_x     = (AW+1)'(tree_q[S-1][0]);
    acc_x     = (AW+1)'(accum_q) + sum_x;
    acc_new   = sat_aw(acc_x);
    acc_clamp = ovf_aw(acc_x);
    acc_new_x = (AW+1)'(acc_new);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (beat_vld && beat_acc) begin
      if (state_q == IDLE) state_d = beat_last ? IDLE : ACCUM;
      else if (beat_last)  state_d = IDLE;
    end
  end

  always_comb begin
    accum_d     = accum_q;
    sticky_d    = sticky_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    if (beat_vld) begin
      // Pass beats and single-beat groups share the direct saturation path.
      if (!beat_acc || (state_q == IDLE && beat_last)) begin
        out_valid_d = 1'b1;
        out_data_d  = sat_dw(sum_x);
        out_ovf_d   = ovf_dw(sum_x);
      end
      if (beat_acc) begin
        if (state_q == IDLE) begin
          accum_d  = sum_x[AW-1:0];
          sticky_d = 1'b0;
        end else begin
          accum_d  = acc_new;
          sticky_d = sticky_q | acc_clamp;
          if (beat_last) begin
            out_valid_d = 1'b1;
            out_data_d  = sat_dw(acc_new_x);
            out_ovf_d   = sticky_q | acc_clamp | ovf_dw(acc_new_x);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      accum_q     <= '0;
      sticky_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      accum_q     <= accum_d;
      sticky_q    <= sticky_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_adder_tree_pipe.sv
// Randomized bench for adder_tree_pipe: a per-beat arithmetic model feeds a
// scoreboard of expected results keyed by their due cycle.
module tb_adder_tree_pipe;

  localparam int DW  = 32;
  localparam int N   = 4;
  localparam int S   = 2;
  localparam int AW  = DW + S + 8;
  localparam int LAT = S + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          in_valid = 1'b0, acc_mode = 1'b0, in_last = 1'b0;
  logic [N*DW-1:0] in_data = '0;
  logic          out_valid, out_ovf;
  logic [DW-1:0] out_data;

  logic          u3_valid = 1'b0, u2_valid = 1'b0, tie0 = 1'b0;
  logic [3*DW-1:0] u3_data = '0;
  logic [2*DW-1:0] u2_data = '0;
  logic          u3_out_valid, u3_out_ovf, u2_out_valid, u2_out_ovf;
  logic [DW-1:0] u3_out_data, u2_out_data;

  adder_tree_pipe #(.DWIDTH(DW), .FRAC(24), .N_IN(N), .ACC_GUARD(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .acc_mode(acc_mode), .in_last(in_last),
    .out_valid(out_valid), .out_data(out_data), .out_ovf(out_ovf));

  adder_tree_pipe #(.DWIDTH(DW), .FRAC(24), .N_IN(3), .ACC_GUARD(8)) u_n3 (
    .clk(clk), .rst_n(rst_n), .in_valid(u3_valid), .in_data(u3_data),
    .acc_mode(tie0), .in_last(tie0),
    .out_valid(u3_out_valid), .out_data(u3_out_data), .out_ovf(u3_out_ovf));

  adder_tree_pipe #(.DWIDTH(DW), .FRAC(24), .N_IN(2), .ACC_GUARD(8)) u_n2 (
    .clk(clk), .rst_n(rst_n), .in_valid(u2_valid), .in_data(u2_data),
    .acc_mode(tie0), .in_last(tie0),
    .out_valid(u2_out_valid), .out_data(u2_out_data), .out_ovf(u2_out_ovf));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int due; logic [DW-1:0] data; logic ovf; } exp_t;
  exp_t q[$];

  int n_chk = 0, n_pass = 0;
  bit mon_en = 0, dir_mode = 0;
  int last_cyc = 0;

  bit     m_group = 0;
  longint m_acc = 0;
  bit     m_sticky = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
  endtask

  function automatic longint clampw(input longint x, input int w);
    longint lim;
    lim = longint'(1) <<< (w - 1);
    if (x > lim - 1) return lim - 1;
    if (x < -lim) return -lim;
    return x;
  endfunction

  function automatic void push_exp(input int due, input longint v, input bit ovf);
    exp_t e;
    e.due = due; e.data = v[DW-1:0]; e.ovf = ovf;
    q.push_back(e);
  endfunction

  function automatic void model(input logic [N*DW-1:0] ops, input bit a, input bit l, input int due);
    longint s, t;
    bit ca;
    s = 0;
    for (int i = 0; i < N; i++) s += longint'($signed(ops[i*DW +: DW]));
    if (!a) begin
      if (!dir_mode) push_exp(due, clampw(s, DW), clampw(s, DW) != s);
    end else if (!m_group) begin
      m_acc = s; m_sticky = 0;
      if (l) begin
        if (!dir_mode) push_exp(due, clampw(s, DW), clampw(s, DW) != s);
      end else m_group = 1;
    end else begin
      t  = m_acc + s;
      ca = clampw(t, AW) != t;
      m_acc = clampw(t, AW);
      m_sticky |= ca;
      if (l) begin
        if (!dir_mode) push_exp(due, clampw(m_acc, DW), m_sticky || (clampw(m_acc, DW) != m_acc));
        m_group = 0;
      end
    end
  endfunction

  task automatic drive(input bit v, input bit a, input bit l, input logic [N*DW-1:0] ops);
    @(posedge clk);
    #1;
    in_valid = v; acc_mode = a; in_last = l; in_data = ops;
    last_cyc = cyc;
    if (v) model(ops, a, l, cyc + LAT);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++)
      drive(1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)), {$urandom, $urandom, $urandom, $urandom});
  endtask

  function automatic logic [N*DW-1:0] rnd_ops();
    logic [N*DW-1:0] r;
    logic [DW-1:0] w;
    for (int i = 0; i < N; i++) begin
      w = $urandom;
      case ($urandom_range(3))
        0: w = DW'($signed(w) >>> 6);
        1: w = $urandom_range(1) ? 32'h7FFF_FFFF : 32'h8000_0000;
        default: ;
      endcase
      r[i*DW +: DW] = w;
    end
    return r;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    bit due;
    if (mon_en) begin
      if (!rst_n) begin
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
      end else begin
        due = (q.size() > 0) && (q[0].due == cyc);
        chk("out_valid", out_valid, due);
        if (due) begin
          e = q.pop_front();
          chk("out_data", out_data, e.data);
          chk("out_ovf", out_ovf, e.ovf);
        end
      end
    end
  end

  initial begin
    int c0;
    repeat (2) @(negedge clk);
    chk("reset_valid", out_valid, 0);
    chk("reset_data", out_data, 0);
    chk("reset_ovf", out_ovf, 0);
    @(posedge clk); #3 rst_n = 1'b1;
    mon_en = 1;

    dir_mode = 1;
    drive(1, 0, 0, {32'h0040_0000, 32'hFF80_0000, 32'h0200_0000, 32'h0100_0000});
    push_exp(last_cyc + LAT, 64'h02C0_0000, 0);
    drive(1, 0, 0, {4{32'h7FFF_FFFF}});
    push_exp(last_cyc + LAT, 64'h7FFF_FFFF, 1);
    drive(1, 0, 0, {4{32'h8000_0000}});
    push_exp(last_cyc + LAT, 64'h8000_0000, 1);
    drive(1, 0, 0, {32'h0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF});
    push_exp(last_cyc + LAT, 64'h7FFF_FFFF, 0);
    idle(2);

    drive(1, 1, 0, {4{32'h0040_0000}});
    drive(1, 0, 0, {32'h0, 32'h0, 32'h0, 32'h0010_0000});
    push_exp(last_cyc + LAT, 64'h0010_0000, 0);
    drive(1, 1, 0, {32'h0, 32'h0, 32'h0080_0000, 32'h0080_0000});
    drive(1, 1, 1, {32'h0100_0000, 32'h0, 32'h0, 32'h0});
    push_exp(last_cyc + LAT, 64'h0300_0000, 0);
    idle(4);

    drive(1, 1, 0, {32'h0, 32'h0, 32'h0, 32'h0100_0000});
    drive(1, 1, 0, {32'h0, 32'h0, 32'h0, 32'h0100_0000});
    idle(1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    q.delete(); m_group = 0; m_acc = 0; m_sticky = 0;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_data", out_data, 0);
    chk("midrst_ovf", out_ovf, 0);
    #3 rst_n = 1'b1;
    drive(1, 1, 1, {32'h0, 32'h0, 32'h0, 32'h0080_0000});
    push_exp(last_cyc + LAT, 64'h0080_0000, 0);
    idle(4);
    dir_mode = 0;

    for (int b = 1; b <= 16; b++) drive(!(b == 5 || b == 9), 0, 0, rnd_ops());
    idle(4);

    for (int b = 0; b < 300; b++)
      drive($urandom_range(9) < 8, 1'($urandom_range(1)), $urandom_range(2) == 0, rnd_ops());
    idle(6);
    chk("queue_drained", q.size(), 0);
    mon_en = 0;

    @(posedge clk); #1;
    u3_valid = 1; u3_data = {3{32'h0100_0000}}; c0 = cyc;
    @(posedge clk); #1 u3_valid = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (u3_out_valid) break;
    end
    chk("n3_valid", u3_out_valid, 1);
    chk("n3_latency", cyc - c0, 3);
    chk("n3_data", u3_out_data, 32'h0300_0000);
    chk("n3_ovf", u3_out_ovf, 0);
    @(negedge clk);
    chk("n3_strobe_len", u3_out_valid, 0);

    @(posedge clk); #1;
    u2_valid = 1; u2_data = {32'hFF00_0000, 32'h0100_0000}; c0 = cyc;
    @(posedge clk); #1 u2_valid = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (u2_out_valid) break;
    end
    chk("n2_valid", u2_out_valid, 1);
    chk("n2_latency", cyc - c0, 2);
    chk("n2_data", u2_out_data, 32'h0);
    chk("n2_ovf", u2_out_ovf, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
